// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among N_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (timeout_err).
module uart_tx_arbiter #(
  parameter int          N_REQ          = 4,
  parameter int          HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic               timeout_err,
  output logic [7:0]         uart_in,
  output logic               uart_load,
  output logic               uart_tx_start,
  input  logic               uart_done
);
  localparam int            IW       = $clog2(N_REQ);
  localparam int            CW       = $clog2(HOLD_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;
  state_t state, next_state;

  logic [IW-1:0]    ptr, owner, sel, next_ptr;
  logic             sel_vld;
  logic [7:0]       sel_byte;
  logic [N_REQ-1:0] sel_onehot, owner_onehot;
  logic [CW-1:0]    hold_cnt;
  logic             sticky;
  logic             sync_p0, sync_p1, sync_p2;
  logic             edge_det, pending, grant, fire, expire;

  // First requester at or above ptr, wrapping.
  always_comb begin
    int j;
    j          = 0;
    sel        = '0;
    sel_vld    = 1'b0;
    sel_byte   = '0;
    sel_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!sel_vld && req[IW'(j)]) begin
        sel     = IW'(j);
        sel_vld = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == IW'(i)) begin
        sel_byte      = req_data[8*i +: 8];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < N_REQ; i++)
      if (owner == IW'(i)) owner_onehot[i] = 1'b1;
  end

  assign next_ptr = (owner == LAST_IDX) ? '0 : owner + IW'(1);
  assign edge_det = sync_p1 & ~sync_p2;
  assign pending  = edge_det | sticky;
  assign grant    = (state == IDLE) && sel_vld;
  // An edge caught during HOLD fires done on the HOLD->WAIT edge, so it shows in the first WAIT cycle.
  assign fire     = ((state == HOLD) && (hold_cnt == '0) && pending) ||
                    ((state == WAIT) && (done == '0) && pending);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sel_vld) next_state = HOLD;
      HOLD:    if (hold_cnt == '0) next_state = WAIT;
      WAIT:    if ((done != '0) || expire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    uart_load     = (state == HOLD);
    uart_tx_start = (state == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      sync_p2  <= 1'b0;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      sticky   <= 1'b0;
      uart_in  <= '0;
      gnt      <= '0;
      done     <= '0;
    end else begin
      sync_p0 <= uart_done;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      gnt     <= '0;
      done    <= '0;
      if (grant) begin
        owner    <= sel;
        uart_in  <= sel_byte;
        gnt      <= sel_onehot;
        hold_cnt <= CW'(HOLD_CYCLES - 1);
        sticky   <= 1'b0;
      end else if ((state == HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - CW'(1);
      end
      if (fire) begin
        done   <= owner_onehot;
        ptr    <= next_ptr;
        sticky <= 1'b0;
      end else if (expire) begin
        ptr <= next_ptr;
      end else if (edge_det && (state != IDLE)) begin
        sticky <= 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wait_cnt;

  assign expire = (state == WAIT) && (done == '0) && !pending && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      wait_cnt    <= (state == WAIT) ? wait_cnt + 32'd1 : '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign expire         = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected gnt/done/timeout events,
// a forked monitor pops and compares them whenever the DUT pulses one.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int HC = 16;
  localparam int TO = 100;
  localparam int K_GNT  = 0;
  localparam int K_DONE = 1;
  localparam int K_TMO  = 2;

  typedef struct {
    int         kind;
    logic [3:0] vec;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic [3:0]  req       = '0;
  logic [31:0] req_data  = '0;
  logic        uart_done = 1'b0;
  logic [3:0]  gnt, done;
  logic        busy, timeout_err, uart_load, uart_tx_start;
  logic [7:0]  uart_in;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(N), .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .busy(busy), .timeout_err(timeout_err),
    .uart_in(uart_in), .uart_load(uart_load), .uart_tx_start(uart_tx_start),
    .uart_done(uart_done)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_GNT:   return "gnt";
      K_DONE:  return "done";
      default: return "timeout_err";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic score(input int kind, input logic [3:0] vec, input logic [7:0] data);
    exp_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got %b byte=%h with nothing expected", kname(kind), vec, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.vec !== vec || (kind == K_GNT && e.data !== data)) begin
        n_fail++;
        $display("FAIL scoreboard_%s: got %s %b byte=%h, expected %s %b byte=%h",
                 kname(e.kind), kname(kind), vec, data, kname(e.kind), e.vec, e.data);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset) begin
        if (done != '0)  score(K_DONE, done, 8'h00);
        if (timeout_err) score(K_TMO, 4'b0000, 8'h00);
        if (gnt != '0)   score(K_GNT, gnt, uart_in);
      end
    end
  endtask

  // Called at a negedge with the FSM idle; runs one full transaction.
  task automatic serve(input logic [3:0] rv, input int idx, input logic [7:0] byt,
                       input bit keep, input bit early);
    int n;
    q.push_back('{K_GNT, 4'(1 << idx), byt});
    q.push_back('{K_DONE, 4'(1 << idx), 8'h00});
    req = rv;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 40);
    check("gnt_latency", n, 1);
    check("strobes_busy_at_gnt", {29'd0, uart_load, uart_tx_start, busy}, 32'h7);
    if (!keep) req = '0;
    n = 1;
    while (uart_load && n < 40) begin
      @(posedge clk);
      if (early && n == 4) begin #1 uart_done = 1'b1; end
      @(negedge clk);
      if (uart_load) n++;
    end
    check("strobe_cycles", n, HC);
    check("wait_busy", busy, 1);
    check("uart_in_stable", uart_in, byt);
    if (early) begin
      check("early_done_first_wait", done, 4'(1 << idx));
      @(negedge clk);
    end else begin
      @(posedge clk);
      #1 uart_done = 1'b1;
      n = 0;
      do begin @(posedge clk); n++; @(negedge clk); end while (done == '0 && n < 10);
      check("done_latency", n, 3);
      @(negedge clk);
    end
    check("busy_after_done", busy, 0);
    uart_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    fork
      monitor();
    join_none
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {12'd0, gnt, done, busy, timeout_err, uart_load, uart_tx_start, uart_in}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single request from requester 1.
    req_data = 32'h0000_A500;
    serve(4'b0010, 1, 8'hA5, 0, 0);

    // Fairness from ptr 0 with all requests held.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req_data = 32'h4332_2110;
    serve(4'b1111, 0, 8'h10, 1, 0);
    serve(4'b1111, 1, 8'h21, 1, 0);
    serve(4'b1111, 2, 8'h32, 1, 0);
    serve(4'b1111, 3, 8'h43, 1, 0);
    serve(4'b1111, 0, 8'h10, 0, 0);

    // Request withdrawn between edges: no grant.
    req = 4'b0100;
    #2 req = 4'b0000;
    repeat (4) @(negedge clk);
    check("withdrawn_busy", busy, 0);

    // Wrap and round-robin search past ptr.
    serve(4'b1000, 3, 8'h43, 0, 0);
    serve(4'b0001, 0, 8'h10, 0, 0);
    serve(4'b0101, 2, 8'h32, 0, 0);
    serve(4'b0101, 0, 8'h10, 0, 1);

    // Reset while a byte is in WAIT.
    req_data = 32'h433C_2110;
    q.push_back('{K_GNT, 4'b0100, 8'h3C});
    req = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 40);
    check("reset_case_gnt_latency", n, 1);
    req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (uart_load && n < 40);
    check("reset_case_hold", n, HC);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("reset_midwait_outputs",
             {12'd0, gnt, done, busy, timeout_err, uart_load, uart_tx_start, uart_in}, 0);
    uart_done = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    uart_done = 1'b0;
    check("after_reset_idle", busy, 0);
    req_data = 32'h4332_2110;
    serve(4'b1111, 0, 8'h10, 0, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: ptr is 1, requesters 0 and 1 pending, uart_done never rises.
    q.push_back('{K_GNT, 4'b0010, 8'h21});
    q.push_back('{K_TMO, 4'b0000, 8'h00});
    req = 4'b0011;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 40);
    check("tmo_gnt_latency", n, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (uart_load && n < 40);
    check("tmo_hold", n, HC);
    n = 0;
    while (!timeout_err && n < 200) begin @(negedge clk); n++; end
    check("timeout_cycles", n, TO);
    check("timeout_no_done", done, 0);
    serve(4'b0011, 0, 8'h10, 0, 0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
